spawn_scheduler: RTL and testbench
==================================

// Module: spawn_scheduler
// PURPOSE
//  Frame-paced scheduler that shares the 1-12 pseudo-random source among NUM_REQ spawn requesters
//  (car lanes, log lanes, bonus items). Every PERIOD_FRAMES frames it grants one requester,
//  round-robin, together with a latched random value. Sits between random_1_12 and the object blocks.
// PARAMETERS
//  NUM_REQ        4   number of spawn requesters (2..8)
//  PERIOD_FRAMES  30  frames between spawn opportunities (>=1)
//  ACK_TIMEOUT    15  clk cycles a grant is held without ack before it is dropped (>=1)
// PORTS
//  clk          in   1        system clock
//  resetN       in   1        asynchronous, active-low reset
//  enable       in   1        game running; low forces IDLE
//  startOfFrame in   1        one-cycle pulse per video frame
//  random       in   4        value from random_1_12, legal range 1..12
//  req          in   NUM_REQ  level requests, one per requester
//  ack          in   NUM_REQ  one-cycle ack from the granted requester
//  grant        out  NUM_REQ  one-hot grant, registered
//  spawn_valid  out  1        high while grant is non-zero
//  spawn_value  out  4        latched random value, always 1..12
//  missed       out  1        one-cycle pulse when a grant times out
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, spawn_valid=0, spawn_value=1, missed=0, frame_cnt=0, timeout_cnt=0,
//   rr_ptr=NUM_REQ-1 (requester 0 has top priority first).
//  FSM states: IDLE, WAIT, ARB, GRANT.
//  IDLE: outputs cleared. enable=1 -> WAIT with frame_cnt=0.
//  WAIT: each startOfFrame increments frame_cnt. startOfFrame while frame_cnt==PERIOD_FRAMES-1 ->
//   ARB, frame_cnt=0. Frames are counted only in WAIT; pulses in ARB/GRANT are ignored.
//  ARB: if |req, pick the first asserted req scanning from rr_ptr+1 upward, wrapping modulo NUM_REQ.
//   Register the one-hot grant and spawn_value in the same edge; go to GRANT. If req==0, stay in ARB
//   (the opportunity is held, not lost) until some req asserts.
//  spawn_value clamp: random in 1..12 is passed unchanged; 0 or 13..15 -> 1.
//  GRANT: grant and spawn_valid held constant; timeout_cnt counts up from 0 each cycle.
//   ack on the granted bit -> clear grant, rr_ptr=granted index, timeout_cnt=0, go to WAIT.
//   ack bits on non-granted requesters are ignored. Deasserting req during GRANT has no effect.
//   timeout_cnt==ACK_TIMEOUT-1 with no ack -> clear grant, pulse missed for 1 cycle,
//   rr_ptr=granted index (a stuck requester cannot starve the others), go to WAIT.
//   ack and timeout in the same cycle: the ack wins and missed stays 0.
//  Latency: period-ending startOfFrame sampled at edge t -> ARB after t; grant visible after t+1
//   if req was asserted during ARB.
//  enable=0 in any state -> IDLE at the next edge. grant, spawn_valid and missed are cleared.
//   rr_ptr is preserved; frame_cnt and timeout_cnt are cleared.
//  resetN asserted mid-operation -> all registers return to reset values immediately (async).
//  Widths: frame_cnt $clog2(PERIOD_FRAMES+1), timeout_cnt $clog2(ACK_TIMEOUT+1), rr_ptr $clog2(NUM_REQ).
// STRUCTURE
//  Package frog_spawn_pkg: typedef enum logic [1:0] {IDLE,WAIT,ARB,GRANT} spawn_state_t;
//   localparams RAND_MIN=4'd1, RAND_MAX=4'd12.
//  Sub-module spawn_rr_arbiter: combinational round-robin pick from (req, rr_ptr) -> one-hot + index,
//   plus an any_req flag. FSM, counters, clamp and output registers stay in spawn_scheduler.
// TESTING (NUM_REQ=4, PERIOD_FRAMES=3, ACK_TIMEOUT=4)
//  1 Reset, enable=1, req=4'b1111, random=7, 3 frames -> grant=0001, spawn_value=7, one cycle after ARB.
//  2 ack[0] pulses, random=12, 3 more frames -> grant=0010, spawn_value=12. Continue: order 0100, 1000, 0001.
//  3 req=4'b0100, granted, no ack -> grant held 4 cycles, then missed=1 for 1 cycle, grant=0, state=WAIT.
//  4 req=0 at period end -> stays in ARB with grant=0. req=4'b1000 later -> grant=1000 at the next edge.
//  5 random=0, then random=15 at ARB -> spawn_value=1 both times. Wrong-bit ack ignored; ack+timeout same cycle -> missed=0.
//  6 enable=0 during GRANT -> grant=0 at the next edge, IDLE. Async resetN mid-WAIT -> all outputs reset at once.

Source files
------------

// File: rtl/frog_spawn_pkg.sv
// Shared types and helpers for the frog spawn scheduler.
package frog_spawn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARB   = 2'd2,
    GRANT = 2'd3
  } spawn_state_t;

  localparam logic [3:0] RAND_MIN = 4'd1;
  localparam logic [3:0] RAND_MAX = 4'd12;

  // Values outside the legal 1..12 range from random_1_12 fall back to 1.
  function automatic logic [3:0] clamp_random(input logic [3:0] r);
    if ((r >= RAND_MIN) && (r <= RAND_MAX)) begin
      return r;
    end
    return RAND_MIN;
  endfunction

endpackage

// File: rtl/spawn_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after rr_ptr_i,
// wrapping modulo NUM_REQ. Returns one-hot, index and an any-request flag.
module spawn_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]         gnt_onehot_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       any_req_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  assign any_req_o = |req_i;

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ; the first hit wins.
  always_comb begin
    int                 cand;
    logic [PTR_W-1:0]   cidx;
    logic               found;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    cand         = 0;
    cidx         = '0;
    found        = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr_i) + i) % NUM_REQ;
      cidx = PTR_W'(cand);
      if (!found && req_i[cidx]) begin
        found              = 1'b1;
        gnt_onehot_o[cidx] = 1'b1;
        gnt_idx_o          = cidx;
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Frame-paced round-robin spawn scheduler. Every PERIOD_FRAMES frames one
// requester is granted together with a latched (clamped) random value.
// Handshake: grant/spawn_valid stay constant until the granted requester
// pulses its ack bit for one cycle; a grant not acked within ACK_TIMEOUT
// cycles is dropped and flagged with a one-cycle missed pulse.
module spawn_scheduler
  import frog_spawn_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int PERIOD_FRAMES = 30,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable,
  input  logic               startOfFrame,
  input  logic [3:0]         random,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic               spawn_valid,
  output logic [3:0]         spawn_value,
  output logic               missed,
  output logic [1:0]         state_o
);

  localparam int FC_W  = $clog2(PERIOD_FRAMES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  spawn_state_t       state_q, state_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [TO_W-1:0]    timeout_cnt_q, timeout_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [3:0]         spawn_value_q, spawn_value_d;
  logic               missed_q, missed_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;

  spawn_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .gnt_onehot_o (arb_onehot),
    .gnt_idx_o    (arb_idx),
    .any_req_o    (arb_any)
  );

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
      gidx_q        <= '0;
      grant_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_value_q <= RAND_MIN;
      missed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      gidx_q        <= gidx_d;
      grant_q       <= grant_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_value_q <= spawn_value_d;
      missed_q      <= missed_d;
    end
  end

  // Next-state logic: frame pacing, arbitration, ack/timeout handling.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    spawn_valid_d = spawn_valid_q;
    spawn_value_d = spawn_value_q;
    missed_d      = 1'b0;
    if (!enable) begin
      // rr_ptr survives a pause so fairness carries over.
      state_d       = IDLE;
      grant_d       = '0;
      spawn_valid_d = 1'b0;
      frame_cnt_d   = '0;
      timeout_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = WAIT;
          frame_cnt_d = '0;
        end
        WAIT: begin
          if (startOfFrame) begin
            if (frame_cnt_q == FC_W'(PERIOD_FRAMES - 1)) begin
              state_d     = ARB;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        ARB: begin
          // With no requests the opportunity is held here, not lost.
          if (arb_any) begin
            grant_d       = arb_onehot;
            gidx_d        = arb_idx;
            spawn_valid_d = 1'b1;
            spawn_value_d = clamp_random(random);
            timeout_cnt_d = '0;
            state_d       = GRANT;
          end
        end
        GRANT: begin
          if (|(ack & grant_q)) begin
            grant_d       = '0;
            spawn_valid_d = 1'b0;
            rr_ptr_d      = gidx_q;
            timeout_cnt_d = '0;
            state_d       = WAIT;
          end else if (timeout_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
            // Advance the pointer anyway so a stuck requester cannot starve others.
            grant_d       = '0;
            spawn_valid_d = 1'b0;
            rr_ptr_d      = gidx_q;
            timeout_cnt_d = '0;
            missed_d      = 1'b1;
            state_d       = WAIT;
          end else begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_value = spawn_value_q;
  assign missed      = missed_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler with NUM_REQ=4, PERIOD_FRAMES=3, ACK_TIMEOUT=4.
module tb_spawn_scheduler;
  import frog_spawn_pkg::*;

  localparam int N  = 4;
  localparam int PF = 3;
  localparam int AT = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic         enable;
  logic         startOfFrame;
  logic [3:0]   random;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic         spawn_valid;
  logic [3:0]   spawn_value;
  logic         missed;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_last = N - 1;     // last served requester in the reference model
  logic [N-1:0] exp_q[$];   // expected grant sequence

  spawn_scheduler #(.NUM_REQ(N), .PERIOD_FRAMES(PF), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
    .random(random), .req(req), .ack(ack), .grant(grant),
    .spawn_valid(spawn_valid), .spawn_value(spawn_value), .missed(missed),
    .state_o(state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_clamp(input int r);
    if (r >= 1 && r <= 12) return 4'(r);
    return 4'd1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Deliver PF frame pulses; on return the DUT has just entered ARB.
  task automatic run_period();
    for (int k = 0; k < PF; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (k < PF - 1) tick();
    end
  endtask

  // One full spawn with immediate ack; checks grant, value, and return to WAIT.
  task automatic spawn_and_ack(input logic [N-1:0] r, input int rnd, input string tag);
    int idx;
    logic [N-1:0] exp_g;
    req = r; random = 4'(rnd);
    run_period();
    idx = model_pick(r, mdl_last);
    exp_g = N'(1) << idx;
    exp_q.push_back(exp_g);
    n_checks++;
    if (state_o !== 2'(ARB) || grant !== '0) $display("FAIL %s_arb: state=%0d grant=%b, want state=%0d grant=0", tag, state_o, grant, ARB);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== exp_q.pop_front() || spawn_value !== model_clamp(rnd) || spawn_valid !== 1'b1)
      $display("FAIL %s_grant: grant=%b value=%0d valid=%b, want grant=%b value=%0d valid=1", tag, grant, spawn_value, spawn_valid, exp_g, model_clamp(rnd));
    else n_pass++;
    ack = exp_g;
    tick();
    ack = '0;
    mdl_last = idx;
    n_checks++;
    if (grant !== '0 || spawn_valid !== 1'b0 || missed !== 1'b0 || state_o !== 2'(WAIT))
      $display("FAIL %s_ack: grant=%b valid=%b missed=%b state=%0d, want 0/0/0/%0d", tag, grant, spawn_valid, missed, state_o, WAIT);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; random = 4'd7; req = '0; ack = '0;
    #12;
    n_checks++;
    if (grant !== '0 || spawn_valid !== 1'b0 || spawn_value !== 4'd1 || missed !== 1'b0 || state_o !== 2'(IDLE))
      $display("FAIL reset: grant=%b valid=%b value=%0d missed=%b state=%0d, want 0/0/1/0/%0d", grant, spawn_valid, spawn_value, missed, state_o, IDLE);
    else n_pass++;
    resetN = 1'b1;
    mdl_last = N - 1;
    tick();
  endtask

  task automatic test_round_robin();
    enable = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 2'(WAIT)) $display("FAIL idle_to_wait: state=%0d, want %0d", state_o, WAIT);
    else n_pass++;
    spawn_and_ack(4'b1111, 7, "rr0");
    spawn_and_ack(4'b1111, 12, "rr1");
    spawn_and_ack(4'b1111, $urandom_range(1, 12), "rr2");
    spawn_and_ack(4'b1111, $urandom_range(1, 12), "rr3");
    spawn_and_ack(4'b1111, $urandom_range(1, 12), "rr4");
  endtask

  task automatic test_timeout();
    logic [N-1:0] exp_g;
    req = 4'b0100; random = 4'd5;
    run_period();
    tick();
    exp_g = N'(1) << model_pick(4'b0100, mdl_last);
    for (int c = 0; c < AT; c++) begin
      n_checks++;
      if (grant !== exp_g || missed !== 1'b0) $display("FAIL to_hold%0d: grant=%b missed=%b, want %b/0", c, grant, missed, exp_g);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (grant !== '0 || missed !== 1'b1 || state_o !== 2'(WAIT))
      $display("FAIL to_drop: grant=%b missed=%b state=%0d, want 0/1/%0d", grant, missed, state_o, WAIT);
    else n_pass++;
    tick();
    n_checks++;
    if (missed !== 1'b0) $display("FAIL to_pulse: missed=%b, want 0", missed);
    else n_pass++;
    mdl_last = 2;
  endtask

  task automatic test_hold_arb();
    req = '0; random = 4'd9;
    run_period();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (state_o !== 2'(ARB) || grant !== '0) $display("FAIL arb_hold%0d: state=%0d grant=%b, want %0d/0", c, state_o, grant, ARB);
      else n_pass++;
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || spawn_value !== 4'd9) $display("FAIL arb_late: grant=%b value=%0d, want 1000/9", grant, spawn_value);
    else n_pass++;
    ack = 4'b1000;
    tick();
    ack = '0;
    mdl_last = 3;
  endtask

  task automatic test_clamp_ack();
    int idx;
    logic [N-1:0] exp_g;
    spawn_and_ack(4'b1111, 0, "clamp0");
    req = 4'b1111; random = 4'd0;
    run_period();
    random = 4'd15;
    tick();
    idx = model_pick(4'b1111, mdl_last);
    exp_g = N'(1) << idx;
    n_checks++;
    if (grant !== exp_g || spawn_value !== 4'd1) $display("FAIL clamp15: grant=%b value=%0d, want %b/1", grant, spawn_value, exp_g);
    else n_pass++;
    ack = ~exp_g;
    tick();
    ack = '0;
    n_checks++;
    if (grant !== exp_g || missed !== 1'b0) $display("FAIL wrong_ack: grant=%b missed=%b, want %b/0", grant, missed, exp_g);
    else n_pass++;
    tick();
    tick();
    ack = exp_g;
    tick();
    ack = '0;
    n_checks++;
    if (grant !== '0 || missed !== 1'b0 || state_o !== 2'(WAIT))
      $display("FAIL ack_vs_timeout: grant=%b missed=%b state=%0d, want 0/0/%0d", grant, missed, state_o, WAIT);
    else n_pass++;
    tick();
    n_checks++;
    if (missed !== 1'b0) $display("FAIL ack_vs_timeout_late: missed=%b, want 0", missed);
    else n_pass++;
    mdl_last = idx;
  endtask

  task automatic test_random();
    int idx, rnd, d;
    logic [N-1:0] r, exp_g;
    bit acked;
    for (int it = 0; it < 20; it++) begin
      r = N'($urandom_range(1, 15));
      rnd = $urandom_range(0, 15);
      d = $urandom_range(0, 5);
      req = r; random = 4'(rnd);
      run_period();
      tick();
      idx = model_pick(r, mdl_last);
      exp_g = N'(1) << idx;
      n_checks++;
      if (grant !== exp_g || spawn_value !== model_clamp(rnd))
        $display("FAIL rnd%0d_grant: grant=%b value=%0d, want %b/%0d", it, grant, spawn_value, exp_g, model_clamp(rnd));
      else n_pass++;
      acked = 1'b0;
      for (int c = 0; c < AT; c++) begin
        if (c == d) begin
          ack = exp_g;
          tick();
          ack = '0;
          acked = 1'b1;
          break;
        end
        tick();
      end
      n_checks++;
      if (grant !== '0 || missed !== !acked || state_o !== 2'(WAIT))
        $display("FAIL rnd%0d_end: grant=%b missed=%b state=%0d, want 0/%0d/%0d", it, grant, missed, state_o, !acked, WAIT);
      else n_pass++;
      mdl_last = idx;
    end
  endtask

  task automatic test_enable_reset();
    int idx;
    logic [N-1:0] exp_g;
    req = 4'b1111; random = 4'd3;
    run_period();
    tick();
    idx = model_pick(4'b1111, mdl_last);
    enable = 1'b0;
    tick();
    n_checks++;
    if (grant !== '0 || spawn_valid !== 1'b0 || missed !== 1'b0 || state_o !== 2'(IDLE))
      $display("FAIL disable: grant=%b valid=%b missed=%b state=%0d, want 0/0/0/%0d", grant, spawn_valid, missed, state_o, IDLE);
    else n_pass++;
    // Pointer is preserved across the pause: the same requester wins again.
    enable = 1'b1;
    tick();
    run_period();
    tick();
    exp_g = N'(1) << idx;
    n_checks++;
    if (grant !== exp_g) $display("FAIL ptr_kept: grant=%b, want %b", grant, exp_g);
    else n_pass++;
    // Asynchronous reset while granting, away from the clock edge.
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || spawn_valid !== 1'b0 || spawn_value !== 4'd1 || state_o !== 2'(IDLE))
      $display("FAIL async_grant: grant=%b valid=%b value=%0d state=%0d, want 0/0/1/%0d", grant, spawn_valid, spawn_value, state_o, IDLE);
    else n_pass++;
    resetN = 1'b1;
    mdl_last = N - 1;
    tick();
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 2'(IDLE) || grant !== '0 || missed !== 1'b0)
      $display("FAIL async_wait: state=%0d grant=%b missed=%b, want %0d/0/0", state_o, grant, missed, IDLE);
    else n_pass++;
    resetN = 1'b1;
    tick();
    // After reset requester 0 has top priority again.
    tick();
    spawn_and_ack(4'b1111, 11, "post_reset");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_hold_arb();
    test_clamp_ack();
    test_random();
    test_enable_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
